// File: rtl/vslidedown_seq_unit_if.sv
// Request/beat bundle between the register-file read side and the vslidedown sequencer.
// The mask ports exist only when VSLIDEDOWN_MASK_EN is defined.
interface vslidedown_seq_unit_if #(
  parameter int VLEN_BITS = 128
);
  logic                     in_valid;
  logic                     in_ready;
  logic                     sew;
  logic                     lmul;
  logic [4:0]               uimm;
  logic [VLEN_BITS*4-1:0]   vs2_bus;
  logic                     out_valid;
  logic                     out_ready;
  logic [1:0]               out_idx;
  logic [VLEN_BITS-1:0]     out_data;
  logic                     out_last;
`ifdef VSLIDEDOWN_MASK_EN
  logic                     vm;
  logic [63:0]              v0_mask;
  logic [VLEN_BITS*4-1:0]   vd_prev_bus;
`endif

  modport master (
`ifdef VSLIDEDOWN_MASK_EN
    output vm, v0_mask, vd_prev_bus,
`endif
    output in_valid, sew, lmul, uimm, vs2_bus, out_ready,
    input  in_ready, out_valid, out_idx, out_data, out_last
  );

  modport slave (
`ifdef VSLIDEDOWN_MASK_EN
    input  vm, v0_mask, vd_prev_bus,
`endif
    input  in_valid, sew, lmul, uimm, vs2_bus, out_ready,
    output in_ready, out_valid, out_idx, out_data, out_last
  );
endinterface

// File: rtl/vslidedown_seq_unit.sv
// Multi-cycle vslidedown.vi engine: captures a source group in one beat, then streams the
// slid destination one register per beat. Optional masking is enabled by VSLIDEDOWN_MASK_EN.
module vslidedown_seq_unit #(
  parameter int VLEN_BITS = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vslidedown_seq_unit_if.slave bus
);
  localparam int GRP_BITS = VLEN_BITS * 4;
  localparam int EPR8     = VLEN_BITS / 8;
  localparam int EPR32    = VLEN_BITS / 32;
  localparam int NB8      = EPR8 * 4;
  localparam int NB32     = EPR32 * 4;
  localparam int B_AW     = $clog2(NB8);
  localparam int W_AW     = $clog2(NB32);
  localparam int EW_MIN   = $clog2(NB8 + 32);
  localparam int EW       = (EW_MIN > 8) ? EW_MIN : 8;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state_q, state_d;
  logic                   sew_q, sew_d;
  logic                   lmul_q, lmul_d;
  logic [4:0]             uimm_q, uimm_d;
  logic [GRP_BITS-1:0]    vs2_q, vs2_d;
  logic [VLEN_BITS-1:0]   out_data_q, out_data_d;
  logic [1:0]             out_idx_q, out_idx_d;
  logic                   out_last_q, out_last_d;

  logic                   accept, advance;
  logic                   calc_sew, calc_lmul;
  logic [4:0]             calc_uimm;
  logic [1:0]             calc_k;
  logic [NB8-1:0][7:0]    src8;
  logic [NB32-1:0][31:0]  src32;
  logic [VLEN_BITS-1:0]   beat_data;
  logic [EW-1:0]          vlmax, elem, src_e;

`ifdef VSLIDEDOWN_MASK_EN
  logic                   vm_q, vm_d;
  logic [63:0]            v0_q, v0_d;
  logic [GRP_BITS-1:0]    vd_prev_q, vd_prev_d;
  logic                   calc_vm;
  logic [63:0]            calc_v0;
  logic [NB8-1:0][7:0]    prev8;
  logic [NB32-1:0][31:0]  prev32;
  logic                   active;
`endif

  assign accept  = (state_q == IDLE) && bus.in_valid;
  assign advance = (state_q == SEND) && bus.out_ready && !out_last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = SEND;
      SEND:    if (bus.out_ready && out_last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == SEND);
    bus.out_idx   = out_idx_q;
    bus.out_data  = out_data_q;
    bus.out_last  = out_last_q;
  end

  // The first beat is computed straight from the bus so it can be registered on the accept edge.
  always_comb begin
    calc_sew  = sew_q;
    calc_lmul = lmul_q;
    calc_uimm = uimm_q;
    calc_k    = out_idx_q + 2'd1;
    src8      = vs2_q;
    src32     = vs2_q;
`ifdef VSLIDEDOWN_MASK_EN
    calc_vm   = vm_q;
    calc_v0   = v0_q;
    prev8     = vd_prev_q;
    prev32    = vd_prev_q;
`endif
    if (accept) begin
      calc_sew  = bus.sew;
      calc_lmul = bus.lmul;
      calc_uimm = bus.uimm;
      calc_k    = 2'd0;
      src8      = bus.vs2_bus;
      src32     = bus.vs2_bus;
`ifdef VSLIDEDOWN_MASK_EN
      calc_vm   = bus.vm;
      calc_v0   = bus.v0_mask;
      prev8     = bus.vd_prev_bus;
      prev32    = bus.vd_prev_bus;
`endif
    end
  end

  // Element indices are held in EW bits so e+uimm never wraps before the VLMAX compare.
  always_comb begin
    beat_data = '0;
    vlmax     = '0;
    elem      = '0;
    src_e     = '0;
`ifdef VSLIDEDOWN_MASK_EN
    active    = 1'b1;
`endif
    if (!calc_sew) begin
      vlmax = calc_lmul ? EW'(NB8) : EW'(EPR8);
      for (int j = 0; j < EPR8; j++) begin
        elem  = EW'(calc_k) * EW'(EPR8) + EW'(j);
        src_e = elem + EW'(calc_uimm);
        if (src_e < vlmax) beat_data[j*8 +: 8] = src8[src_e[B_AW-1:0]];
`ifdef VSLIDEDOWN_MASK_EN
        active = calc_vm || ((elem < EW'(64)) && calc_v0[elem[5:0]]);
        if (!active) beat_data[j*8 +: 8] = prev8[elem[B_AW-1:0]];
`endif
      end
    end else begin
      vlmax = calc_lmul ? EW'(NB32) : EW'(EPR32);
      for (int j = 0; j < EPR32; j++) begin
        elem  = EW'(calc_k) * EW'(EPR32) + EW'(j);
        src_e = elem + EW'(calc_uimm);
        if (src_e < vlmax) beat_data[j*32 +: 32] = src32[src_e[W_AW-1:0]];
`ifdef VSLIDEDOWN_MASK_EN
        active = calc_vm || ((elem < EW'(64)) && calc_v0[elem[5:0]]);
        if (!active) beat_data[j*32 +: 32] = prev32[elem[W_AW-1:0]];
`endif
      end
    end
  end

  always_comb begin
    sew_d      = sew_q;
    lmul_d     = lmul_q;
    uimm_d     = uimm_q;
    vs2_d      = vs2_q;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    out_last_d = out_last_q;
`ifdef VSLIDEDOWN_MASK_EN
    vm_d       = vm_q;
    v0_d       = v0_q;
    vd_prev_d  = vd_prev_q;
`endif
    if (accept) begin
      sew_d     = bus.sew;
      lmul_d    = bus.lmul;
      uimm_d    = bus.uimm;
      vs2_d     = bus.vs2_bus;
`ifdef VSLIDEDOWN_MASK_EN
      vm_d      = bus.vm;
      v0_d      = bus.v0_mask;
      vd_prev_d = bus.vd_prev_bus;
`endif
    end
    if (accept || advance) begin
      out_idx_d  = calc_k;
      out_last_d = (calc_k == (calc_lmul ? 2'd3 : 2'd0));
      out_data_d = beat_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sew_q      <= 1'b0;
      lmul_q     <= 1'b0;
      uimm_q     <= '0;
      vs2_q      <= '0;
      out_data_q <= '0;
      out_idx_q  <= '0;
      out_last_q <= 1'b0;
`ifdef VSLIDEDOWN_MASK_EN
      vm_q       <= 1'b0;
      v0_q       <= '0;
      vd_prev_q  <= '0;
`endif
    end else begin
      sew_q      <= sew_d;
      lmul_q     <= lmul_d;
      uimm_q     <= uimm_d;
      vs2_q      <= vs2_d;
      out_data_q <= out_data_d;
      out_idx_q  <= out_idx_d;
      out_last_q <= out_last_d;
`ifdef VSLIDEDOWN_MASK_EN
      vm_q       <= vm_d;
      v0_q       <= v0_d;
      vd_prev_q  <= vd_prev_d;
`endif
    end
  end
endmodule

// File: tb/tb_vslidedown_seq_unit.sv
// Directed scoreboard bench for vslidedown_seq_unit (VLEN_BITS=128); mask case runs only
// when VSLIDEDOWN_MASK_EN is defined.
module tb_vslidedown_seq_unit;
  localparam int VLEN = 128;

  typedef struct {
    logic [1:0]      idx;
    logic [VLEN-1:0] data;
    logic            last;
  } beat_t;

  logic  clk   = 1'b0;
  logic  rst_n = 1'b1;
  int    compared   = 0;
  int    mismatched = 0;
  beat_t sb[$];

  vslidedown_seq_unit_if #(.VLEN_BITS(VLEN)) bus ();
  vslidedown_seq_unit #(.VLEN_BITS(VLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkVal(input string tag, input logic [VLEN-1:0] obs, input logic [VLEN-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pushBeat(input logic [1:0] idx, input logic [VLEN-1:0] data, input logic last);
    beat_t b;
    b.idx  = idx;
    b.data = data;
    b.last = last;
    sb.push_back(b);
  endtask

  // Reference: build the whole destination group element by element, then cut it into registers.
  task automatic pushModel(input logic s, input logic l, input logic [4:0] u, input logic [4*VLEN-1:0] v);
    logic [4*VLEN-1:0] dst;
    int esz, nb, vlmax;
    dst   = '0;
    esz   = s ? 32 : 8;
    nb    = l ? 4 : 1;
    vlmax = nb * VLEN / esz;
    for (int e = 0; e < vlmax; e++)
      if (e + int'(u) < vlmax)
        for (int bi = 0; bi < esz; bi++)
          dst[e*esz + bi] = v[(e + int'(u))*esz + bi];
    for (int k = 0; k < nb; k++)
      pushBeat(2'(k), dst[k*VLEN +: VLEN], k == nb - 1);
  endtask

  task automatic fillRand(output logic [4*VLEN-1:0] v);
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
  endtask

  // Called on a negedge; returns on the negedge after the accept edge with inputs scrambled.
  task automatic applyStimulus(input logic s, input logic l, input logic [4:0] u, input logic [4*VLEN-1:0] v);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkVal("accept_wait", VLEN'(n < 50), VLEN'(1));
    bus.sew      = s;
    bus.lmul     = l;
    bus.uimm     = u;
    bus.vs2_bus  = v;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.sew      = ~s;
    bus.lmul     = ~l;
    bus.uimm     = ~u;
    bus.vs2_bus  = ~v;
  endtask

  task automatic checkOutput(input string tag);
    beat_t exp;
    int n = 0;
    bus.out_ready = 1'b1;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkVal({tag, "_valid"}, VLEN'(bus.out_valid), VLEN'(1));
    if (sb.size() == 0) begin
      checkVal({tag, "_sb_empty"}, VLEN'(sb.size()), VLEN'(1));
      return;
    end
    exp = sb.pop_front();
    checkVal({tag, "_idx"},  VLEN'(bus.out_idx),  VLEN'(exp.idx));
    checkVal({tag, "_data"}, bus.out_data,        exp.data);
    checkVal({tag, "_last"}, VLEN'(bus.out_last), VLEN'(exp.last));
    @(negedge clk);
  endtask

  task automatic pushCase2();
    pushBeat(2'd0, 128'h00000108_00000107_00000106_00000105, 1'b0);
    pushBeat(2'd1, 128'h0000010c_0000010b_0000010a_00000109, 1'b0);
    pushBeat(2'd2, 128'h00000000_0000010f_0000010e_0000010d, 1'b0);
    pushBeat(2'd3, 128'h0, 1'b1);
  endtask

  initial begin
    logic [4*VLEN-1:0] v_bytes, v_words, v;
    logic s, l;
    logic [4:0] u;
    int seen;

    bus.in_valid  = 1'b0;
    bus.sew       = 1'b0;
    bus.lmul      = 1'b0;
    bus.uimm      = '0;
    bus.vs2_bus   = '0;
    bus.out_ready = 1'b0;
`ifdef VSLIDEDOWN_MASK_EN
    bus.vm          = 1'b1;
    bus.v0_mask     = '0;
    bus.vd_prev_bus = '0;
`endif
    for (int i = 0; i < 64; i++) v_bytes[i*8 +: 8] = 8'(i);
    for (int i = 0; i < 16; i++) v_words[i*32 +: 32] = 32'h100 + 32'(i);

    #1 rst_n = 1'b0;
    @(negedge clk);
    checkVal("rst_out_valid", VLEN'(bus.out_valid), VLEN'(0));
    checkVal("rst_out_data",  bus.out_data,         VLEN'(0));
    checkVal("rst_out_idx",   VLEN'(bus.out_idx),   VLEN'(0));
    checkVal("rst_out_last",  VLEN'(bus.out_last),  VLEN'(0));
    @(negedge clk);
    rst_n = 1'b1;
    checkVal("rst_in_ready", VLEN'(bus.in_ready), VLEN'(1));

    $display("[TB] case 1: single register int8, uimm=3");
    pushBeat(2'd0, 128'h0000000f0e0d0c0b0a09080706050403, 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd3, v_bytes);
    checkVal("c1_latency", VLEN'(bus.out_valid), VLEN'(1));
    checkOutput("c1");
    checkVal("c1_done_valid", VLEN'(bus.out_valid), VLEN'(0));
    checkVal("c1_done_ready", VLEN'(bus.in_ready),  VLEN'(1));

    $display("[TB] case 2: 4-register int32, uimm=5");
    pushCase2();
    applyStimulus(1'b1, 1'b1, 5'd5, v_words);
    for (int k = 0; k < 4; k++) checkOutput($sformatf("c2_b%0d", k));

    $display("[TB] case 3: stall on beat 1");
    pushCase2();
    applyStimulus(1'b1, 1'b1, 5'd5, v_words);
    checkOutput("c3_b0");
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkVal("c3_hold_data",  bus.out_data,         sb[0].data);
      checkVal("c3_hold_idx",   VLEN'(bus.out_idx),   VLEN'(1));
      checkVal("c3_hold_valid", VLEN'(bus.out_valid), VLEN'(1));
      checkVal("c3_hold_ready", VLEN'(bus.in_ready),  VLEN'(0));
      @(negedge clk);
    end
    for (int k = 1; k < 4; k++) checkOutput($sformatf("c3_b%0d", k));

    $display("[TB] case 4: uimm=0 copy and out-of-range offsets");
    fillRand(v);
    for (int k = 0; k < 4; k++) pushBeat(2'(k), v[k*VLEN +: VLEN], k == 3);
    applyStimulus(1'b0, 1'b1, 5'd0, v);
    for (int k = 0; k < 4; k++) checkOutput($sformatf("c4_copy_b%0d", k));
    fillRand(v);
    pushBeat(2'd0, '0, 1'b1);
    applyStimulus(1'b1, 1'b0, 5'd31, v);
    checkOutput("c4_u31");
    fillRand(v);
    for (int k = 0; k < 4; k++) pushBeat(2'(k), '0, k == 3);
    applyStimulus(1'b1, 1'b1, 5'd16, v);
    for (int k = 0; k < 4; k++) checkOutput($sformatf("c4_vlmax_b%0d", k));

    $display("[TB] random requests against the reference model");
    for (int t = 0; t < 8; t++) begin
      fillRand(v);
      s = 1'($urandom);
      l = 1'($urandom);
      u = 5'($urandom);
      pushModel(s, l, u, v);
      applyStimulus(s, l, u, v);
      for (int k = 0; k < (l ? 4 : 1); k++) checkOutput($sformatf("rnd%0d_b%0d", t, k));
    end

    $display("[TB] case 5: reset mid-group");
    pushCase2();
    applyStimulus(1'b1, 1'b1, 5'd5, v_words);
    checkOutput("c5_b0");
    checkOutput("c5_b1");
    rst_n = 1'b0;
    #1;
    checkVal("c5_rst_valid", VLEN'(bus.out_valid), VLEN'(0));
    checkVal("c5_rst_data",  bus.out_data,         VLEN'(0));
    checkVal("c5_rst_idx",   VLEN'(bus.out_idx),   VLEN'(0));
    checkVal("c5_rst_last",  VLEN'(bus.out_last),  VLEN'(0));
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    checkVal("c5_in_ready", VLEN'(bus.in_ready), VLEN'(1));
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    checkVal("c5_no_beats", VLEN'(seen), VLEN'(0));

`ifdef VSLIDEDOWN_MASK_EN
    $display("[TB] case 6: masked slide");
    bus.vm          = 1'b0;
    bus.v0_mask     = 64'hAAAA;
    bus.vd_prev_bus = '1;
    pushBeat(2'd0, 128'h00ff00ff0eff0cff0aff08ff06ff04ff, 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd3, v_bytes);
    bus.vm          = 1'b1;
    bus.v0_mask     = '0;
    bus.vd_prev_bus = '0;
    checkOutput("c6");
`endif

    checkVal("sb_drained", VLEN'(sb.size()), VLEN'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
